// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_fifo.sv
// Word FIFO for the UART transmitter; DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO. Define UART_TX_PARITY_EN to insert a parity bit
// after the data bits; without it parity_odd is ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLOCK_DIV  = 104,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    input  logic                          parity_odd,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    // state  | meaning
    // IDLE   | line idle, pops the head word when the FIFO is non-empty
    // START  | start bit
    // DATA   | DATA_BITS data bits, LSB first
    // PARITY | parity bit (UART_TX_PARITY_EN builds only)
    // STOP   | STOP_BITS stop bits

    localparam int              CW        = $clog2(CLOCK_DIV);
    localparam int              IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLOCK_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    uart_state_t          state;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 bit_end;
    logic                 line_level;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign pop      = (state == IDLE) && !empty;
    assign tx_ready = !full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign bit_end  = (bit_cnt == CNT_LAST);

    always_comb begin
        line_level = IDLE_LEVEL;
        case (state)
            START:   line_level = START_LEVEL;
            DATA:    line_level = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_level = par_bit;
`endif
            default: line_level = IDLE_LEVEL;
        endcase
    end

    // tx registers the level of the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx <= line_level;
            if (state != IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg <= head;
                        state <= START;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^head) ^ parity_odd;
`endif
                    end
                end
                START: begin
                    if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) state <= STOP;
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            stop_idx <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 and 5-bit/2-stop, CLOCK_DIV=4) checked every cycle
// against a queue-based line model, plus hand-computed frame expectations.
module tb_uart_tx_fifo;
    localparam int CD    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_A = CD * (1 + 8 + PAR + 1);
    localparam int FRAME_B = CD * (1 + 5 + PAR + 2);

    logic       clock;
    logic       reset_n;
    logic       parity_odd;
    logic       valid_a, ready_a, tx_a, busy_a;
    logic [7:0] data_a;
    logic [2:0] count_a;
    logic       valid_b, ready_b, tx_b, busy_b;
    logic [4:0] data_b;
    logic [2:0] count_b;

    int errors = 0;
    int checks = 0;

    int dbits [2] = '{8, 5};
    int sbits [2] = '{1, 2};
    int mq    [2][64];
    int mq_rd [2];
    int mq_wr [2];
    bit ml    [2][2048];
    int ml_rd [2];
    int ml_wr [2];
    int rem   [2];
    bit exp_tx[2];

    bit rec_tx  [2][512];
    bit rec_busy[2][512];
    int push_q[$];
    bit saw_full;
    bit last_par;

    uart_tx_fifo #(.DATA_BITS(8), .CLOCK_DIV(CD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clock(clock), .reset_n(reset_n), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .parity_odd(parity_odd), .tx(tx_a), .busy(busy_a),
        .fifo_count(count_a)
    );

    uart_tx_fifo #(.DATA_BITS(5), .CLOCK_DIV(CD), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clock(clock), .reset_n(reset_n), .tx_valid(valid_b), .tx_data(data_b),
        .tx_ready(ready_b), .parity_odd(parity_odd), .tx(tx_b), .busy(busy_b),
        .fifo_count(count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ---------------- line model ----------------
    function automatic int frame_len(input int d);
        return CD * (1 + dbits[d] + PAR + sbits[d]);
    endfunction

    function automatic int model_count(input int d);
        return mq_wr[d] - mq_rd[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq_rd[d] = 0; mq_wr[d] = 0; ml_rd[d] = 0; ml_wr[d] = 0;
            rem[d] = 0; exp_tx[d] = 1'b1;
        end
    endtask

    task automatic model_append(input int d, input bit level, input int n);
        for (int i = 0; i < n; i++) begin
            ml[d][ml_wr[d] % 2048] = level;
            ml_wr[d]++;
        end
    endtask

    // One clock edge: the line shows the next queued level; a free transmitter takes the head word
    // and queues its whole frame, which then appears on the line from the following edge.
    task automatic model_step(input int d, input bit valid, input int data, input bit podd);
        int n;
        int w;
        bit par;
        n = model_count(d);
        if (ml_rd[d] != ml_wr[d]) begin
            exp_tx[d] = ml[d][ml_rd[d] % 2048];
            ml_rd[d]++;
        end else begin
            exp_tx[d] = 1'b1;
        end
        if (rem[d] > 0) begin
            rem[d]--;
        end else if (n > 0) begin
            w = mq[d][mq_rd[d] % 64];
            mq_rd[d]++;
            par = podd;
            model_append(d, 1'b0, CD);
            for (int b = 0; b < dbits[d]; b++) begin
                model_append(d, bit'((w >> b) & 1), CD);
                par = par ^ bit'((w >> b) & 1);
            end
            if (PAR == 1) model_append(d, par, CD);
            model_append(d, 1'b1, CD * sbits[d]);
            rem[d] = frame_len(d);
        end
        if (valid && n < DEPTH) begin
            mq[d][mq_wr[d] % 64] = data;
            mq_wr[d]++;
        end
    endtask

    initial begin : compare
        model_reset();
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                model_reset();
            end else begin
                model_step(0, valid_a, int'(data_a), parity_odd);
                model_step(1, valid_b, int'(data_b), parity_odd);
            end
            @(negedge clock);
            chk("tx_a",    tx_a,    exp_tx[0]);
            chk("busy_a",  busy_a,  (rem[0] > 0) || (model_count(0) != 0));
            chk("ready_a", ready_a, model_count(0) != DEPTH);
            chk("count_a", count_a, model_count(0));
            chk("tx_b",    tx_b,    exp_tx[1]);
            chk("busy_b",  busy_b,  (rem[1] > 0) || (model_count(1) != 0));
            chk("ready_b", ready_b, model_count(1) != DEPTH);
            chk("count_b", count_b, model_count(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            rec_tx[0][i] = tx_a;  rec_busy[0][i] = busy_a;
            rec_tx[1][i] = tx_b;  rec_busy[1][i] = busy_b;
        end
    endtask

    // Called at a negedge; keeps valid_a high until every queued word has been accepted.
    task automatic push_a_run();
        int guard;
        while (push_q.size() > 0) begin
            valid_a = 1'b1;
            data_a  = 8'(push_q[0]);
            guard   = 0;
            while (!ready_a && guard < 5000) begin
                if (count_a == 3'd4) saw_full = 1'b1;
                @(negedge clock);
                guard++;
            end
            if (!ready_a) begin
                chk("push_a accept timeout", 32'(guard), 0);
                push_q.delete();
            end else begin
                @(negedge clock);
                void'(push_q.pop_front());
            end
        end
        valid_a = 1'b0;
    endtask

    // Decodes one frame from DUT A; returns at the negedge showing the frame's last stop cycle.
    task automatic receive_a(output int w);
        int guard;
        int pos;
        int target;
        w = 0;
        guard = 0;
        while (tx_a !== 1'b0 && guard < 4000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 4000) chk("receive_a start timeout", 32'(guard), 0);
        pos = 0;
        for (int b = 0; b < 8; b++) begin
            target = CD * (1 + b) + 2;
            repeat (target - pos) @(negedge clock);
            pos = target;
            if (tx_a) w = w | (1 << b);
        end
        if (PAR == 1) begin
            target = CD * 9 + 2;
            repeat (target - pos) @(negedge clock);
            pos = target;
            last_par = tx_a;
        end
        repeat (FRAME_A - 1 - pos) @(negedge clock);
        chk("receive_a stop level", tx_a, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [10:0] sym;
        int bad;
        int s0;
        int w;
        int lows;

        reset_n = 1'b0; parity_odd = 1'b0;
        valid_a = 1'b0; data_a = '0;
        valid_b = 1'b0; data_b = '0;
        repeat (3) @(negedge clock);
        chk("reset tx_a",    tx_a,    1);
        chk("reset busy_a",  busy_a,  0);
        chk("reset ready_a", ready_a, 1);
        chk("reset count_a", count_a, 0);
        chk("reset tx_b",    tx_b,    1);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // 0xA5 on 8-bit DUT: start, 1,0,1,0,0,1,0,1, (parity 0), stop
`ifdef UART_TX_PARITY_EN
        sym = 11'b10101001010;
`else
        sym = 11'b01101001010;
`endif
        valid_a = 1'b1; data_a = 8'hA5;
        @(negedge clock);
        valid_a = 1'b0;
        record(1 + FRAME_A + 2);
        chk("a5 line before start", rec_tx[0][0], 1);
        chk("a5 first start cycle", rec_tx[0][1], 0);
        bad = 0;
        for (int j = 0; j < FRAME_A; j++) if (rec_tx[0][1 + j] !== sym[j / CD]) bad++;
        chk("a5 frame bit errors", 32'(bad), 0);
        chk("a5 busy before last stop", rec_busy[0][1 + FRAME_A - 2], 1);
        chk("a5 busy at last stop",     rec_busy[0][1 + FRAME_A - 1], 0);
        chk("a5 line after frame",      rec_tx[0][1 + FRAME_A], 1);
        repeat (5) @(negedge clock);

        // Three words on consecutive edges: back-to-back frames with one idle cycle
        push_q = '{1, 2, 3};
        fork
            push_a_run();
            record(3 * (FRAME_A + 1) + 4);
        join
        s0 = 2;
        bad = 0;
        for (int j = 0; j <= s0 + 2 * (FRAME_A + 1) + FRAME_A - 2; j++) if (!rec_busy[0][j]) bad++;
        chk("b2b busy low cycles", 32'(bad), 0);
        chk("b2b busy after third frame", rec_busy[0][s0 + 2 * (FRAME_A + 1) + FRAME_A - 1], 0);
        chk("b2b idle gap 1",  rec_tx[0][s0 + FRAME_A], 1);
        chk("b2b start 2",     rec_tx[0][s0 + FRAME_A + 1], 0);
        chk("b2b idle gap 2",  rec_tx[0][s0 + 2 * FRAME_A + 1], 1);
        chk("b2b start 3",     rec_tx[0][s0 + 2 * FRAME_A + 2], 0);
        for (int k = 0; k < 3; k++) begin
            w = 0;
            for (int b = 0; b < 8; b++)
                if (rec_tx[0][s0 + k * (FRAME_A + 1) + CD * (1 + b) + 2]) w = w | (1 << b);
            chk("b2b word order", 32'(w), 32'(k + 1));
        end
        repeat (5) @(negedge clock);

        // Six words held valid into a four-deep FIFO: stall, then drain in order
        saw_full = 1'b0;
        push_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        fork
            push_a_run();
            begin
                for (int k = 0; k < 6; k++) begin
                    receive_a(w);
                    chk("stall word order", 32'(w), 32'(8'h11 + k));
                end
            end
        join
        chk("stall saw full with ready low", saw_full, 1);
        repeat (3) @(negedge clock);
        chk("stall drained count", count_a, 0);
        chk("stall drained busy",  busy_a,  0);

        // 0x07 parity
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        valid_a = 1'b1; data_a = 8'h07;
        @(negedge clock);
        valid_a = 1'b0;
        record(1 + FRAME_A + 2);
        chk("even parity of 0x07", rec_tx[0][1 + CD * 9 + 2], 1);
        chk("parity frame busy before end", rec_busy[0][1 + 44 - 2], 1);
        chk("parity frame 44 cycles",       rec_busy[0][1 + 44 - 1], 0);
        repeat (3) @(negedge clock);
        parity_odd = 1'b1;
        valid_a = 1'b1; data_a = 8'h07;
        @(negedge clock);
        valid_a = 1'b0;
        record(1 + FRAME_A + 2);
        chk("odd parity of 0x07", rec_tx[0][1 + CD * 9 + 2], 0);
        chk("odd parity frame 44 cycles", rec_busy[0][1 + 44 - 1], 0);
`else
        parity_odd = 1'b1;
        valid_a = 1'b1; data_a = 8'h07;
        @(negedge clock);
        valid_a = 1'b0;
        record(1 + FRAME_A + 2);
        chk("no parity: stop follows data", rec_tx[0][1 + CD * 9 + 2], 1);
        chk("no parity frame busy before end", rec_busy[0][1 + 40 - 2], 1);
        chk("no parity frame 40 cycles",       rec_busy[0][1 + 40 - 1], 0);
`endif
        parity_odd = 1'b0;
        repeat (5) @(negedge clock);

        // Reset during data bit 3 with two words still queued
        push_q = '{8'h33, 8'h44, 8'h55};
        push_a_run();
        repeat (17) @(negedge clock);
        chk("pre-reset bit 3 of 0x33", tx_a, 0);
        chk("pre-reset queued words",  count_a, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("reset abort tx",    tx_a,    1);
        chk("reset abort count", count_a, 0);
        chk("reset abort busy",  busy_a,  0);
        chk("reset abort ready", ready_a, 1);
        @(negedge clock);
        #1 reset_n = 1'b1;

        // First edge after release accepts: 0x1F on the 5-bit, two-stop DUT
        valid_b = 1'b1; data_b = 5'h1F;
        @(negedge clock);
        valid_b = 1'b0;
        chk("accept right after reset", count_b, 1);
        record(1 + FRAME_B + 2);
        chk("b line before start", rec_tx[1][0], 1);
        lows = 0;
        for (int j = 1; j <= CD; j++) if (!rec_tx[1][j]) lows++;
        chk("b start low cycles", 32'(lows), 4);
        lows = 0;
        for (int j = CD + 1; j <= FRAME_B + 2; j++) if (!rec_tx[1][j]) lows++;
        chk("b data and stop high", 32'(lows), 0);
        chk("b busy before last stop", rec_busy[1][1 + FRAME_B - 2], 1);
        chk("b frame length",          rec_busy[1][1 + FRAME_B - 1], 0);
        lows = 0;
        for (int j = 0; j < 1 + FRAME_B + 2; j++) if (!rec_tx[0][j]) lows++;
        for (int j = 0; j < 100; j++) begin
            @(negedge clock);
            if (!tx_a) lows++;
        end
        chk("no frames after reset", 32'(lows), 0);
        chk("a idle after reset", busy_a, 0);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
